y86_execute_pipe: RTL and testbench
===================================

Name: y86_execute_pipe

Overview:
Parametrised, pipelined Y86 execute stage for the PIPE processor: one registered E/M boundary with valid/ready handshake, a condition-code register, and condition evaluation for jXX and cmovXX.
Generalises the single-cycle 64-bit execute unit in four ways: configurable width, correct word-sized stack adjust, back-pressure, and exception-aware CC updates.
Sits between decode (vala/valb already forwarded) and memory.

Parameters:
WIDTH, 64, datapath width in bits; must be a multiple of 8 and at least 16.
STAT_W, 3, width of the status code.
REG_W, 4, register-ID width; ID 4'hF (RNONE) means no destination.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  decode offers an instruction
in_ready  out  1  execute can accept this cycle
in_icode  in  4  instruction code
in_ifun  in  4  function code
in_stat  in  STAT_W  status from earlier stages
in_valc  in  WIDTH  constant / displacement
in_vala  in  WIDTH  operand A
in_valb  in  WIDTH  operand B
in_dste  in  REG_W  destination for valE
in_dstm  in  REG_W  destination for valM
squash_cc  in  1  memory or writeback stage holds an exception; block CC writes
flush  in  1  branch mispredict; kill the instruction in E and the one arriving
out_valid  out  1  E/M register holds an instruction
out_ready  in  1  memory stage accepts
out_icode  out  4  registered icode
out_stat  out  STAT_W  registered status
out_vale  out  WIDTH  ALU result
out_vala  out  WIDTH  passthrough of vala
out_cnd  out  1  condition result
out_dste  out  REG_W  destination, RNONE if cmov not taken
out_dstm  out  REG_W  passthrough of dstm
cc_zf, cc_sf, cc_of  out  1 each  current condition codes

Behaviour:
- Reset (asynchronous, takes effect immediately): out_valid=0, all out_* data=0, out_dste=out_dstm=RNONE, out_stat=AOK, ZF=1, SF=0, OF=0.
- Handshake:
  - in_ready = !out_valid || out_ready; combinational, with no dependence on in_valid.
  - Accept when in_valid && in_ready; results are registered at that edge, so latency is 1 cycle.
  - out_valid && !out_ready: hold all out_* stable.
- ALU (result taken modulo 2^WIDTH):
  - OPq fun 0: valB+valA. fun 1: valB−valA. fun 2: AND. fun 3: XOR.
  - rrmovq/cmovXX: vale=0+valA.
  - irmovq: vale=valC.
  - rmmovq/mrmovq: vale=valB+valC.
  - call/pushq: vale=valB−WIDTH/8.
  - ret/popq: vale=valB+WIDTH/8.
  - halt/nop/jXX: vale=0.
- CC update:
  - Only OPq with a valid fun, on acceptance, when in_stat==AOK && !squash_cc && !flush.
  - ZF = (result==0). SF = result[WIDTH-1].
  - OF, add: operands share a sign and the result sign differs.
  - OF, sub: valB and valA signs differ and the result sign differs from valB.
  - OF, logic ops: 0.
- Cnd uses the CC value before this instruction's own update.
  - ifun 0 always: 1.
  - ifun 1 le: (SF^OF)|ZF. ifun 2 l: SF^OF. ifun 3 e: ZF.
  - ifun 4 ne: !ZF. ifun 5 ge: !(SF^OF). ifun 6 g: !(SF^OF)&!ZF.
  - Other icodes: out_cnd=0.
- cmovXX (icode 2) with Cnd=0: out_dste=RNONE.
- Invalid icode (>11) or invalid ifun for OPq/jXX/cmov (>6, OPq >3):
  - out_stat=INS, vale=0, no CC write, dste=dstm=RNONE.
  - Otherwise out_stat=in_stat.
- Non-AOK in_stat: pass through; dste/dstm forced to RNONE; no CC write.
- Flush: on the edge with flush=1, out_valid←0 and any accept in that cycle is discarded. Flush dominates out_ready stall.
- Simultaneous accept and drain: the new instruction replaces the old in the same edge.
- Reset mid-transfer: the instruction is lost and CC is restored to its reset values.

Decomposition:
- Shared package y86_pkg:
  - icode constants: HALT=0, NOP=1, CMOV=2, IRMOV=3, RMMOV=4, MRMOV=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSH=10, POP=11.
  - ALU fun codes.
  - Condition fun codes.
  - STAT codes: AOK=1, HLT=2, ADR=3, INS=4.
  - RNONE.
- One sub-module, y86_cond_eval: combinational (ifun, ZF, SF, OF) → cnd.
- ALU stays inline, parametrised by WIDTH.

Test Plan:
- Reset, then addq valA=64'h7FFF_FFFF_FFFF_FFFF, valB=1 → vale=64'h8000_0000_0000_0000, next cycle ZF=0, SF=1, OF=1, out_valid after 1 cycle.
- subq valA=5, valB=5, then cmovne (fun 4) → first: vale=0, ZF=1. Second: cnd=0, out_dste=RNONE.
- pushq with valB=64'h100 (WIDTH=64) → vale=64'hF8; repeat at WIDTH=32 with valB=32'h100 → vale=32'hFC.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* stable; release → next instruction accepted the same cycle.
- addq issued with squash_cc=1, then jl (fun 2) → CC unchanged from reset, cnd=0.
- icode=4'hC → out_stat=INS, no CC change. flush asserted while accepting → out_valid=0 next cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 PIPE execute stage.
//   - instruction codes, ALU function codes, condition function codes
//   - status codes and the "no register" ID
//   - instr_valid(): decides whether an icode/ifun pair is a legal instruction
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT  = 4'h0,
    I_NOP   = 4'h1,
    I_CMOV  = 4'h2,
    I_IRMOV = 4'h3,
    I_RMMOV = 4'h4,
    I_MRMOV = 4'h5,
    I_OPQ   = 4'h6,
    I_JXX   = 4'h7,
    I_CALL  = 4'h8,
    I_RET   = 4'h9,
    I_PUSH  = 4'hA,
    I_POP   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    A_ADD = 4'h0,
    A_SUB = 4'h1,
    A_AND = 4'h2,
    A_XOR = 4'h3
  } alu_fun_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_fun_e;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  // OPq accepts only the four ALU functions; jXX/cmovXX accept the seven
  // condition functions; every other icode up to popq ignores ifun.
  function automatic logic instr_valid(input logic [3:0] icode, input logic [3:0] ifun);
    logic ok;
    ok = 1'b1;
    if (icode > I_POP) begin
      ok = 1'b0;
    end else if (icode == I_OPQ) begin
      ok = (ifun <= A_XOR);
    end else if ((icode == I_JXX) || (icode == I_CMOV)) begin
      ok = (ifun <= C_G);
    end else begin
      ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/y86_cond_eval.sv
// Condition evaluation for jXX and cmovXX.
//   ifun_i : condition function code
//   zf_i, sf_i, of_i : condition codes as they stand before the instruction
//   cnd_o  : 1 when the condition holds; 0 for unknown function codes
module y86_cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun_i,
  input  logic       zf_i,
  input  logic       sf_i,
  input  logic       of_i,
  output logic       cnd_o
);

  logic lt_s;

  // Signed "less than" as seen through the flags.
  assign lt_s = sf_i ^ of_i;

  // Map the condition function onto the flag combination it tests.
  always_comb begin
    cnd_o = 1'b0;
    case (ifun_i)
      C_YES:   cnd_o = 1'b1;
      C_LE:    cnd_o = lt_s | zf_i;
      C_L:     cnd_o = lt_s;
      C_E:     cnd_o = zf_i;
      C_NE:    cnd_o = ~zf_i;
      C_GE:    cnd_o = ~lt_s;
      C_G:     cnd_o = ~lt_s & ~zf_i;
      default: cnd_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_execute_pipe.sv
// Pipelined Y86 execute stage with a registered E/M boundary.
//   clk, reset_n         : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  : decode-side handshake (in_ready is independent of in_valid)
//   in_icode .. in_dstm  : decoded instruction with forwarded operands
//   squash_cc            : a later stage holds an exception; CC must not change
//   flush                : mispredict; kills the E/M entry and any instruction arriving
//   out_valid / out_ready: memory-side handshake
//   out_icode .. out_dstm: registered E/M contents
//   cc_zf, cc_sf, cc_of  : current condition codes
module y86_execute_pipe
  import y86_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAT_W = 3,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [WIDTH-1:0]  in_valc,
  input  logic [WIDTH-1:0]  in_vala,
  input  logic [WIDTH-1:0]  in_valb,
  input  logic [REG_W-1:0]  in_dste,
  input  logic [REG_W-1:0]  in_dstm,
  input  logic              squash_cc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [STAT_W-1:0] out_stat,
  output logic [WIDTH-1:0]  out_vale,
  output logic [WIDTH-1:0]  out_vala,
  output logic              out_cnd,
  output logic [REG_W-1:0]  out_dste,
  output logic [REG_W-1:0]  out_dstm,
  output logic              cc_zf,
  output logic              cc_sf,
  output logic              cc_of
);

  localparam int                MSB        = WIDTH - 1;
  // Stack pointer moves by one machine word, not a fixed 8 bytes.
  localparam logic [WIDTH-1:0]  WORD_BYTES = WIDTH'(WIDTH / 8);
  localparam logic [STAT_W-1:0] ST_AOK     = STAT_W'(S_AOK);
  localparam logic [STAT_W-1:0] ST_INS     = STAT_W'(S_INS);
  localparam logic [REG_W-1:0]  R_NONE     = REG_W'(RNONE);

  // E/M register and condition codes.
  logic              valid_q, valid_d;
  logic [3:0]        icode_q, icode_d;
  logic [STAT_W-1:0] stat_q,  stat_d;
  logic [WIDTH-1:0]  vale_q,  vale_d;
  logic [WIDTH-1:0]  vala_q,  vala_d;
  logic              cnd_q,   cnd_d;
  logic [REG_W-1:0]  dste_q,  dste_d;
  logic [REG_W-1:0]  dstm_q,  dstm_d;
  logic              zf_q, zf_d;
  logic              sf_q, sf_d;
  logic              of_q, of_d;

  // Combinational view of the offered instruction.
  logic              accept_s;
  logic              ins_ok_s;
  logic              is_cond_s;
  logic              cond_raw_s;
  logic              cnd_s;
  logic              cc_we_s;
  logic [WIDTH-1:0]  add_s;
  logic [WIDTH-1:0]  sub_s;
  logic [WIDTH-1:0]  alu_s;
  logic              alu_of_s;
  logic [WIDTH-1:0]  vale_s;
  logic [STAT_W-1:0] stat_s;
  logic [REG_W-1:0]  dste_s;
  logic [REG_W-1:0]  dstm_s;

  assign in_ready = ~valid_q | out_ready;
  assign accept_s = in_valid & in_ready;

  assign ins_ok_s  = instr_valid(in_icode, in_ifun);
  assign is_cond_s = (in_icode == I_JXX) || (in_icode == I_CMOV);

  // Condition uses the flags as they were before this instruction.
  y86_cond_eval u_cond_eval (
    .ifun_i (in_ifun),
    .zf_i   (zf_q),
    .sf_i   (sf_q),
    .of_i   (of_q),
    .cnd_o  (cond_raw_s)
  );

  assign cnd_s = is_cond_s & ins_ok_s & cond_raw_s;

  assign add_s = in_valb + in_vala;
  assign sub_s = in_valb - in_vala;

  // ALU: result modulo 2^WIDTH plus signed overflow for add/sub.
  always_comb begin
    alu_s    = {WIDTH{1'b0}};
    alu_of_s = 1'b0;
    case (in_icode)
      I_OPQ: begin
        case (in_ifun)
          A_ADD: begin
            alu_s    = add_s;
            alu_of_s = (in_vala[MSB] == in_valb[MSB]) && (add_s[MSB] != in_vala[MSB]);
          end
          A_SUB: begin
            alu_s    = sub_s;
            alu_of_s = (in_vala[MSB] != in_valb[MSB]) && (sub_s[MSB] != in_valb[MSB]);
          end
          A_AND:   alu_s = in_valb & in_vala;
          A_XOR:   alu_s = in_valb ^ in_vala;
          default: alu_s = {WIDTH{1'b0}};
        endcase
      end
      I_CMOV:          alu_s = in_vala;
      I_IRMOV:         alu_s = in_valc;
      I_RMMOV, I_MRMOV: alu_s = in_valb + in_valc;
      I_CALL, I_PUSH:  alu_s = in_valb - WORD_BYTES;
      I_RET, I_POP:    alu_s = in_valb + WORD_BYTES;
      default:         alu_s = {WIDTH{1'b0}};
    endcase
  end

  assign vale_s = ins_ok_s ? alu_s : {WIDTH{1'b0}};
  assign stat_s = ins_ok_s ? in_stat : ST_INS;

  // Destination squashing: illegal or faulting instructions write nothing,
  // and an untaken cmov drops only its valE destination.
  always_comb begin
    dste_s = in_dste;
    dstm_s = in_dstm;
    if (!ins_ok_s || (in_stat != ST_AOK)) begin
      dste_s = R_NONE;
      dstm_s = R_NONE;
    end else if ((in_icode == I_CMOV) && !cnd_s) begin
      dste_s = R_NONE;
      dstm_s = in_dstm;
    end else begin
      dste_s = in_dste;
      dstm_s = in_dstm;
    end
  end

  // CC writes are blocked by any exception in flight and by a flush.
  assign cc_we_s = accept_s && (in_icode == I_OPQ) && ins_ok_s &&
                   (in_stat == ST_AOK) && !squash_cc && !flush;

  // E/M next state: flush kills, accept loads (also replacing a draining entry),
  // drain empties, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    stat_d  = stat_q;
    vale_d  = vale_q;
    vala_d  = vala_q;
    cnd_d   = cnd_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      icode_d = in_icode;
      stat_d  = stat_s;
      vale_d  = vale_s;
      vala_d  = in_vala;
      cnd_d   = cnd_s;
      dste_d  = dste_s;
      dstm_d  = dstm_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Condition code next state.
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (cc_we_s) begin
      zf_d = (alu_s == {WIDTH{1'b0}});
      sf_d = alu_s[MSB];
      of_d = alu_of_s;
    end else begin
      zf_d = zf_q;
      sf_d = sf_q;
      of_d = of_q;
    end
  end

  // State registers; reset restores an empty E/M slot and the initial flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      icode_q <= 4'h0;
      stat_q  <= ST_AOK;
      vale_q  <= {WIDTH{1'b0}};
      vala_q  <= {WIDTH{1'b0}};
      cnd_q   <= 1'b0;
      dste_q  <= R_NONE;
      dstm_q  <= R_NONE;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      icode_q <= icode_d;
      stat_q  <= stat_d;
      vale_q  <= vale_d;
      vala_q  <= vala_d;
      cnd_q   <= cnd_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign out_valid = valid_q;
  assign out_icode = icode_q;
  assign out_stat  = stat_q;
  assign out_vale  = vale_q;
  assign out_vala  = vala_q;
  assign out_cnd   = cnd_q;
  assign out_dste  = dste_q;
  assign out_dstm  = dstm_q;
  assign cc_zf     = zf_q;
  assign cc_sf     = sf_q;
  assign cc_of     = of_q;

endmodule

// File: tb/tb_y86_execute_pipe.sv
module tb_y86_execute_pipe;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_icode;
  logic [3:0]  in_ifun;
  logic [2:0]  in_stat;
  logic [63:0] in_valc;
  logic [63:0] in_vala;
  logic [63:0] in_valb;
  logic [3:0]  in_dste;
  logic [3:0]  in_dstm;
  logic        squash_cc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_icode;
  logic [2:0]  out_stat;
  logic [63:0] out_vale;
  logic [63:0] out_vala;
  logic        out_cnd;
  logic [3:0]  out_dste;
  logic [3:0]  out_dstm;
  logic        cc_zf, cc_sf, cc_of;

  // 32-bit instance sharing control with the 64-bit one.
  logic        r32_in_ready, r32_out_valid, r32_out_cnd;
  logic [3:0]  r32_out_icode, r32_out_dste, r32_out_dstm;
  logic [2:0]  r32_out_stat;
  logic [31:0] r32_out_vale, r32_out_vala;
  logic        r32_zf, r32_sf, r32_of;

  int checks;
  int failures;
  logic cmp_en;

  y86_execute_pipe #(.WIDTH(64), .STAT_W(3), .REG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_stat(in_stat),
    .in_valc(in_valc), .in_vala(in_vala), .in_valb(in_valb),
    .in_dste(in_dste), .in_dstm(in_dstm), .squash_cc(squash_cc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_icode(out_icode),
    .out_stat(out_stat), .out_vale(out_vale), .out_vala(out_vala),
    .out_cnd(out_cnd), .out_dste(out_dste), .out_dstm(out_dstm),
    .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  y86_execute_pipe #(.WIDTH(32), .STAT_W(3), .REG_W(4)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(r32_in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_stat(in_stat),
    .in_valc(in_valc[31:0]), .in_vala(in_vala[31:0]), .in_valb(in_valb[31:0]),
    .in_dste(in_dste), .in_dstm(in_dstm), .squash_cc(squash_cc), .flush(flush),
    .out_valid(r32_out_valid), .out_ready(out_ready), .out_icode(r32_out_icode),
    .out_stat(r32_out_stat), .out_vale(r32_out_vale), .out_vala(r32_out_vala),
    .out_cnd(r32_out_cnd), .out_dste(r32_out_dste), .out_dstm(r32_out_dstm),
    .cc_zf(r32_zf), .cc_sf(r32_sf), .cc_of(r32_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (64-bit) ----------------
  typedef struct packed {
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] vale;
    logic [63:0] vala;
    logic        cnd;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic        cc_we;
    logic        zf;
    logic        sf;
    logic        of;
  } exp_t;

  function automatic exp_t model_exec(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [2:0] st, input logic [63:0] c,
                                      input logic [63:0] a, input logic [63:0] b,
                                      input logic [3:0] de, input logic [3:0] dm,
                                      input logic zf, input logic sf, input logic of);
    exp_t r;
    logic legal;
    logic take;
    logic [64:0] wide;
    r = '0;
    r.icode = ic;
    r.vala  = a;
    legal = (ic <= 4'd11) && !((ic == 4'd6) && (fn > 4'd3)) &&
            !(((ic == 4'd2) || (ic == 4'd7)) && (fn > 4'd6));
    case (fn)
      4'd0: take = 1'b1;
      4'd1: take = (sf != of) || zf;
      4'd2: take = (sf != of);
      4'd3: take = zf;
      4'd4: take = !zf;
      4'd5: take = (sf == of);
      4'd6: take = (sf == of) && !zf;
      default: take = 1'b0;
    endcase
    r.cnd  = legal && ((ic == 4'd2) || (ic == 4'd7)) && take;
    r.stat = legal ? st : 3'd4;
    if (legal) begin
      case (ic)
        4'd6: begin
          // exact signed result in 65 bits; overflow when it does not fit in 64
          case (fn)
            4'd0: begin wide = {a[63], a} + {b[63], b}; r.vale = wide[63:0]; r.of = wide[64] != wide[63]; end
            4'd1: begin wide = {b[63], b} - {a[63], a}; r.vale = wide[63:0]; r.of = wide[64] != wide[63]; end
            4'd2: r.vale = a & b;
            default: r.vale = a ^ b;
          endcase
        end
        4'd2: r.vale = a;
        4'd3: r.vale = c;
        4'd4, 4'd5: r.vale = b + c;
        4'd8, 4'd10: r.vale = b - 64'd8;
        4'd9, 4'd11: r.vale = b + 64'd8;
        default: r.vale = 64'd0;
      endcase
    end
    r.zf = (r.vale == 64'd0);
    r.sf = r.vale[63];
    r.cc_we = legal && (ic == 4'd6) && (st == 3'd1);
    r.dste = (!legal || (st != 3'd1) || ((ic == 4'd2) && !r.cnd)) ? 4'hF : de;
    r.dstm = (!legal || (st != 3'd1)) ? 4'hF : dm;
    return r;
  endfunction

  logic m_valid, m_zf, m_sf, m_of;
  exp_t m_out;
  exp_t m_next;
  logic m_acc;

  always_comb m_next = model_exec(in_icode, in_ifun, in_stat, in_valc, in_vala, in_valb,
                                  in_dste, in_dstm, m_zf, m_sf, m_of);
  assign m_acc = in_valid && (!m_valid || out_ready);

  // model state: one E/M slot plus flags
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_out   <= '0;
      m_zf    <= 1'b1;
      m_sf    <= 1'b0;
      m_of    <= 1'b0;
    end else begin
      if (flush) m_valid <= 1'b0;
      else if (m_acc) begin
        m_valid <= 1'b1;
        m_out   <= m_next;
      end else if (out_ready) m_valid <= 1'b0;
      if (m_acc && m_next.cc_we && !squash_cc && !flush) begin
        m_zf <= m_next.zf;
        m_sf <= m_next.sf;
        m_of <= m_next.of;
      end
    end
  end

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    if (reset_n && cmp_en) begin
      check("m_in_ready", in_ready, !m_valid || out_ready);
      check("m_out_valid", out_valid, m_valid);
      check("m_zf", cc_zf, m_zf);
      check("m_sf", cc_sf, m_sf);
      check("m_of", cc_of, m_of);
      if (m_valid) begin
        check("m_icode", out_icode, m_out.icode);
        check("m_stat", out_stat, m_out.stat);
        check("m_vale", out_vale, m_out.vale);
        check("m_vala", out_vala, m_out.vala);
        check("m_cnd", out_cnd, m_out.cnd);
        check("m_dste", out_dste, m_out.dste);
        check("m_dstm", out_dstm, m_out.dstm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] st,
                       input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] de, input logic [3:0] dm);
    in_icode = ic; in_ifun = fn; in_stat = st;
    in_valc = c; in_vala = a; in_valb = b; in_dste = de; in_dstm = dm;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] st,
                      input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] de, input logic [3:0] dm);
    drive(ic, fn, st, c, a, b, de, dm);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0]  ic;
    logic [3:0]  fn;
    logic [63:0] c;
    logic [63:0] a;
    logic [63:0] b;
  } vec_t;

  vec_t vecs [10];

  initial begin
    checks = 0; failures = 0; cmp_en = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; squash_cc = 1'b0; flush = 1'b0;
    drive(4'h1, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_stat", out_stat, 64'd1);
    check("rst_out_vale", out_vale, 64'd0);
    check("rst_out_dste", out_dste, 64'hF);
    check("rst_out_dstm", out_dstm, 64'hF);
    check("rst_zf", cc_zf, 64'd1);
    check("rst_sf", cc_sf, 64'd0);
    check("rst_of", cc_of, 64'd0);
    check("rst_in_ready", in_ready, 64'd1);
    reset_n = 1'b1;
    cmp_en = 1'b1;

    // addq overflow
    send(4'h6, 4'h0, 3'd1, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h3, 4'hF);
    check("add_valid", out_valid, 64'd1);
    check("add_vale", out_vale, 64'h8000_0000_0000_0000);
    check("add_zf", cc_zf, 64'd0);
    check("add_sf", cc_sf, 64'd1);
    check("add_of", cc_of, 64'd1);

    // subq 5-5 then cmovne (not taken) and cmove (taken)
    send(4'h6, 4'h1, 3'd1, 64'd0, 64'd5, 64'd5, 4'h2, 4'hF);
    check("sub_vale", out_vale, 64'd0);
    check("sub_zf", cc_zf, 64'd1);
    send(4'h2, 4'h4, 3'd1, 64'd0, 64'd9, 64'd0, 4'h5, 4'hF);
    check("cmovne_cnd", out_cnd, 64'd0);
    check("cmovne_dste", out_dste, 64'hF);
    send(4'h2, 4'h3, 3'd1, 64'd0, 64'd9, 64'd0, 4'h5, 4'hF);
    check("cmove_cnd", out_cnd, 64'd1);
    check("cmove_dste", out_dste, 64'h5);

    // pushq word-sized decrement at both widths
    send(4'hA, 4'h0, 3'd1, 64'd0, 64'd0, 64'h100, 4'h4, 4'hF);
    check("push64_vale", out_vale, 64'hF8);
    check("push32_vale", r32_out_vale, 64'hFC);

    // subq overflow, then jl sees SF^OF=1
    send(4'h6, 4'h1, 3'd1, 64'd0, 64'd1, 64'h8000_0000_0000_0000, 4'h1, 4'hF);
    check("subof_vale", out_vale, 64'h7FFF_FFFF_FFFF_FFFF);
    check("subof_of", cc_of, 64'd1);
    send(4'h7, 4'h2, 3'd1, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    check("jl_cnd", out_cnd, 64'd1);

    // back-to-back mix checked by the model
    vecs[0] = '{4'h6, 4'h2, 64'd0, 64'hF0F0, 64'hFF00};
    vecs[1] = '{4'h6, 4'h3, 64'd0, 64'hF0F0, 64'hFF00};
    vecs[2] = '{4'h4, 4'h0, 64'h8, 64'd3, 64'h1000};
    vecs[3] = '{4'h5, 4'h0, 64'h10, 64'd0, 64'h2000};
    vecs[4] = '{4'h8, 4'h0, 64'h80, 64'd0, 64'h100};
    vecs[5] = '{4'h9, 4'h0, 64'd0, 64'd0, 64'hF8};
    vecs[6] = '{4'hB, 4'h0, 64'd0, 64'd0, 64'h200};
    vecs[7] = '{4'h7, 4'h6, 64'h44, 64'd0, 64'd0};
    vecs[8] = '{4'h7, 4'h0, 64'h48, 64'd0, 64'd0};
    vecs[9] = '{4'h0, 4'h0, 64'd0, 64'd0, 64'd0};
    drive(vecs[0].ic, vecs[0].fn, 3'd1, vecs[0].c, vecs[0].a, vecs[0].b, 4'h6, 4'h7);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].ic, vecs[i].fn, 3'd1, vecs[i].c, vecs[i].a, vecs[i].b, 4'h6, 4'h7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // stall: hold out_ready low for three cycles with a waiting instruction
    send(4'h3, 4'h0, 3'd1, 64'h1234, 64'd0, 64'd0, 4'h7, 4'hF);
    out_ready = 1'b0;
    drive(4'h3, 4'h0, 3'd1, 64'h5678, 64'd0, 64'd0, 4'h8, 4'hF);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", in_ready, 64'd0);
      check("stall_vale", out_vale, 64'h1234);
      check("stall_dste", out_dste, 64'h7);
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release_vale", out_vale, 64'h5678);
    check("release_valid", out_valid, 64'd1);

    // reset mid-transfer: entry lost, flags restored
    send(4'h6, 4'h0, 3'd1, 64'd0, 64'd1, 64'd1, 4'h1, 4'hF);
    out_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 64'd0);
    check("midrst_zf", cc_zf, 64'd1);
    check("midrst_stat", out_stat, 64'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;

    // squash_cc blocks the flag write; jl then sees reset flags
    squash_cc = 1'b1;
    send(4'h6, 4'h0, 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 4'hF);
    squash_cc = 1'b0;
    check("squash_vale", out_vale, 64'hFFFF_FFFF_FFFF_FFFE);
    check("squash_zf", cc_zf, 64'd1);
    check("squash_sf", cc_sf, 64'd0);
    send(4'h7, 4'h2, 3'd1, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
    check("squash_jl_cnd", out_cnd, 64'd0);

    // illegal icode and illegal OPq function
    send(4'hC, 4'h0, 3'd1, 64'h5, 64'h5, 64'h5, 4'h2, 4'h3);
    check("badic_stat", out_stat, 64'd4);
    check("badic_vale", out_vale, 64'd0);
    check("badic_dste", out_dste, 64'hF);
    check("badic_dstm", out_dstm, 64'hF);
    send(4'h6, 4'h5, 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 4'hF);
    check("badfn_stat", out_stat, 64'd4);
    check("badfn_sf", cc_sf, 64'd0);

    // non-AOK status passes through without writes
    send(4'h6, 4'h0, 3'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 4'h2);
    check("adr_stat", out_stat, 64'd3);
    check("adr_dste", out_dste, 64'hF);
    check("adr_dstm", out_dstm, 64'hF);
    check("adr_sf", cc_sf, 64'd0);

    // flush while accepting
    flush = 1'b1;
    send(4'h6, 4'h0, 3'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'h1, 4'hF);
    flush = 1'b0;
    check("flush_valid", out_valid, 64'd0);
    check("flush_sf", cc_sf, 64'd0);

    // flush beats a stall
    send(4'h1, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flushstall_valid", out_valid, 64'd0);
    check("flushstall_in_ready", in_ready, 64'd1);
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
